// File: rtl/alu_wb.sv
// alu_wb: ALU result-commit stage.
// Holds the architectural flag register, buffers up to two register-file
// writes in order, drains them through a stallable write port, and reports
// which registers still have a write in flight.
module alu_wb #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RADDR-1:0]      in_ra,
  input  logic [WIDTH-1:0]      in_res,
  input  logic [7:0]            in_fo,
  input  logic                  in_wb_en,
  input  logic                  in_flag_en,
  input  logic                  ext_flag_we,
  input  logic [7:0]            ext_flag_di,
  output logic [7:0]            flags,
  output logic                  rf_wr_en,
  output logic [RADDR-1:0]      rf_wr_addr,
  output logic [WIDTH-1:0]      rf_wr_data,
  input  logic                  rf_wr_ack,
  output logic [(1<<RADDR)-1:0] pending
);

  typedef struct packed {
    logic [RADDR-1:0] addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  // Queue state: occupancy, head slot index, and the two storage slots.
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  entry_t     entry_q [2];
  entry_t     entry_d [2];
  logic [7:0] flags_q, flags_d;

  logic xfer;
  logic push;
  logic pop;
  logic wr_slot;

  // Handshake, push/pop decode and the tail slot for the next push.
  always_comb begin
    in_ready = (count_q != 2'd2);
    xfer     = in_valid && in_ready;
    push     = xfer && in_wb_en;
    pop      = (count_q != 2'd0) && rf_wr_ack;
    // The tail sits one slot past the head when exactly one entry is held.
    wr_slot  = rd_ptr_q ^ count_q[0];
  end

  // Next queue occupancy, head pointer and slot contents.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    entry_d[0] = entry_q[0];
    entry_d[1] = entry_q[1];
    if (push) begin
      entry_d[wr_slot] = '{addr: in_ra, data: in_res};
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Next flag value: the external load overrides an ALU update in the same cycle.
  always_comb begin
    flags_d = flags_q;
    if (ext_flag_we) begin
      flags_d = ext_flag_di;
    end else if (xfer && in_flag_en) begin
      flags_d = in_fo;
    end
  end

  // Control state with synchronous reset; a transfer in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      flags_q  <= 8'h00;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      flags_q  <= flags_d;
    end
  end

  // Slot storage; contents are only meaningful under count_q.
  always_ff @(posedge clk) begin
    // NOTE: the data slots are deliberately not reset; occupancy alone decides validity.
    entry_q[0] <= entry_d[0];
    entry_q[1] <= entry_d[1];
  end

  // Write port, flag output and pending-write bitmap.
  always_comb begin
    flags      = flags_q;
    rf_wr_en   = (count_q != 2'd0);
    rf_wr_addr = entry_q[rd_ptr_q].addr;
    rf_wr_data = entry_q[rd_ptr_q].data;
    pending    = '0;
    for (int i = 0; i < 2; i++) begin
      if ((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(i)))) begin
        pending[entry_q[i].addr] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_wb.sv
// tb_alu_wb: directed checks of the alu_wb commit stage.
module tb_alu_wb;

  localparam int WIDTH = 32;
  localparam int RADDR = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [RADDR-1:0]  in_ra;
  logic [WIDTH-1:0]  in_res;
  logic [7:0]        in_fo;
  logic              in_wb_en;
  logic              in_flag_en;
  logic              ext_flag_we;
  logic [7:0]        ext_flag_di;
  logic [7:0]        flags;
  logic              rf_wr_en;
  logic [RADDR-1:0]  rf_wr_addr;
  logic [WIDTH-1:0]  rf_wr_data;
  logic              rf_wr_ack;
  logic [15:0]       pending;

  int checks   = 0;
  int failures = 0;

  alu_wb #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ra       (in_ra),
    .in_res      (in_res),
    .in_fo       (in_fo),
    .in_wb_en    (in_wb_en),
    .in_flag_en  (in_flag_en),
    .ext_flag_we (ext_flag_we),
    .ext_flag_di (ext_flag_di),
    .flags       (flags),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_wr_ack   (rf_wr_ack),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ra, input logic [31:0] res,
                       input logic wb, input logic fe, input logic [7:0] fo);
    in_valid   = v;
    in_ra      = ra;
    in_res     = res;
    in_wb_en   = wb;
    in_flag_en = fe;
    in_fo      = fo;
  endtask

  initial begin
    reset       = 1'b1;
    ext_flag_we = 1'b0;
    ext_flag_di = 8'h00;
    rf_wr_ack   = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    reset = 1'b0;
    check("rst_flags", 32'(flags), 32'h00);
    check("rst_wr_en", 32'(rf_wr_en), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // 1: single result with ack held high
    rf_wr_ack = 1'b1;
    drive(1'b1, 4'd3, 32'h1234_5678, 1'b1, 1'b1, 8'h05);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("t1_flags", 32'(flags), 32'h05);
    check("t1_wr_en", 32'(rf_wr_en), 32'h1);
    check("t1_addr", 32'(rf_wr_addr), 32'h3);
    check("t1_data", rf_wr_data, 32'h1234_5678);
    check("t1_pending", 32'(pending), 32'h0008);
    step();
    check("t1_drained", 32'(rf_wr_en), 32'h0);
    check("t1_pend_clr", 32'(pending), 32'h0);

    // 2: back-to-back results with the port stalled
    rf_wr_ack = 1'b0;
    drive(1'b1, 4'd1, 32'h0000_0011, 1'b1, 1'b0, 8'h00);
    step();
    check("t2_ready1", 32'(in_ready), 32'h1);
    drive(1'b1, 4'd2, 32'h0000_0022, 1'b1, 1'b0, 8'h00);
    step();
    check("t2_full", 32'(in_ready), 32'h0);
    drive(1'b1, 4'd3, 32'h0000_0033, 1'b1, 1'b0, 8'h00);
    step();
    check("t2_still_full", 32'(in_ready), 32'h0);
    check("t2_head_stable", 32'(rf_wr_addr), 32'h1);
    check("t2_pending", 32'(pending), 32'h0006);
    rf_wr_ack = 1'b1;
    step();
    check("t2_w2_addr", 32'(rf_wr_addr), 32'h2);
    check("t2_w2_data", rf_wr_data, 32'h22);
    check("t2_ready_again", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("t2_w3_addr", 32'(rf_wr_addr), 32'h3);
    check("t2_w3_data", rf_wr_data, 32'h33);
    check("t2_w3_en", 32'(rf_wr_en), 32'h1);
    step();
    check("t2_empty", 32'(rf_wr_en), 32'h0);

    // 3: two writes to the same register
    rf_wr_ack = 1'b0;
    drive(1'b1, 4'd5, 32'h0000_000A, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b1, 4'd5, 32'h0000_000B, 1'b1, 1'b0, 8'h00);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("t3_pend_both", 32'(pending), 32'h0020);
    check("t3_first", rf_wr_data, 32'hA);
    rf_wr_ack = 1'b1;
    step();
    check("t3_pend_one", 32'(pending), 32'h0020);
    check("t3_second", rf_wr_data, 32'hB);
    step();
    check("t3_pend_clr", 32'(pending), 32'h0);
    check("t3_empty", 32'(rf_wr_en), 32'h0);

    // 4: flag-only result
    rf_wr_ack = 1'b0;
    drive(1'b1, 4'd6, 32'hDEAD_BEEF, 1'b0, 1'b1, 8'h80);
    step();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("t4_flags", 32'(flags), 32'h80);
    check("t4_no_wr", 32'(rf_wr_en), 32'h0);
    check("t4_ready", 32'(in_ready), 32'h1);
    check("t4_pending", 32'(pending), 32'h0);

    // 5: external flag load beats ALU flags; write still queues
    ext_flag_we = 1'b1;
    ext_flag_di = 8'h0F;
    drive(1'b1, 4'd2, 32'h0000_0222, 1'b1, 1'b1, 8'hF0);
    step();
    ext_flag_we = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("t5_flags", 32'(flags), 32'h0F);
    check("t5_wr_en", 32'(rf_wr_en), 32'h1);
    check("t5_addr", 32'(rf_wr_addr), 32'h2);
    check("t5_data", rf_wr_data, 32'h222);
    check("t5_pending", 32'(pending), 32'h0004);

    // 6: fill the queue, set flags, then reset mid-operation
    drive(1'b1, 4'd7, 32'h0000_0777, 1'b1, 1'b1, 8'h42);
    step();
    drive(1'b1, 4'd9, 32'h0000_0999, 1'b1, 1'b1, 8'h99);
    check("t6_full", 32'(in_ready), 32'h0);
    check("t6_flags", 32'(flags), 32'h42);
    check("t6_pending", 32'(pending), 32'h0084);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 8'h00);
    check("t6_wr_en", 32'(rf_wr_en), 32'h0);
    check("t6_pend_clr", 32'(pending), 32'h0);
    check("t6_flags_clr", 32'(flags), 32'h00);
    check("t6_ready", 32'(in_ready), 32'h1);
    step();
    check("t6_stay_empty", 32'(rf_wr_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
